adder_checker: RTL and testbench
================================

# adder_checker

Self-checking response monitor for the adder datapath: the receiving end of the stimulus/response exchange that drives operand pairs into an adder and reads back sum and carry. It accepts one observed vector per handshake beat (operands plus the adder's sum and carry), compares it against a golden a+b, counts vectors and mismatches, and raises a verdict once a programmed number of vectors has been checked. It sits beside the half adder and the wider ALU adders as on-chip self-test and in-simulation checking.

## Interface
- WIDTH, 1: operand and sum width. A value of 1 checks a half adder.
- NUM_VECTORS, 4: number of beats per run, in the range 1 to 2^CNT_W-1.
- CNT_W, 16: width of the counters.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  one-cycle pulse that begins a run.
- in_valid  input  1  the observed vector is valid.
- in_ready  output  1  the checker accepts a vector.
- in_a, in_b  input  WIDTH  operands that were applied to the adder.
- in_sum  input  WIDTH  sum produced by the adder.
- in_carry  input  1  carry produced by the adder.
- busy  output  1  a run is in progress.
- done  output  1  one-cycle pulse when the run completes.
- pass  output  1  the verdict of the last completed run.
- vec_count  output  CNT_W  number of beats accepted in this run.
- err_count  output  CNT_W  number of mismatching beats; saturates.
- fail_a, fail_b, fail_sum  output  WIDTH  first failing vector (see Configuration).
- fail_carry  output  1  carry of the first failing vector.

## Operation
- State machine states: IDLE, CHECK, DONE.
- Transitions:
  - IDLE or DONE, with start=1: go to CHECK. Clear vec_count, err_count, pass and the fail_* outputs.
  - CHECK, on the accepted beat that makes vec_count reach NUM_VECTORS: go to DONE.
- A beat is a cycle where in_valid and in_ready are both 1.
- in_ready equals 1 only in CHECK. in_valid in IDLE or DONE is ignored.
- start during CHECK is ignored.
- Golden value: expected = in_a + in_b, computed at WIDTH+1 bits. A beat mismatches when {in_carry,in_sum} differs from expected.
- On every beat, vec_count increments by 1. On a mismatching beat, err_count also increments by 1, but holds at all-ones.
- pass is updated only on entry to DONE, and is 1 exactly when err_count is 0.
- pass, vec_count and err_count hold their values through DONE and IDLE until the next start.
- busy equals 1 exactly in CHECK.

## Timing
- Reset values: every output is 0, and the state is IDLE.
- A reset in any state, including in the middle of a run, forces reset values on the next edge. No verdict is produced for the aborted run.
- start at edge k: busy=1 and in_ready=1 from edge k.
- A beat sampled at edge k: the counters are updated after edge k.
- Completion, when the last beat is at edge k:
  - After edge k: done=1 for exactly one cycle, busy=0, pass is valid, and the state is DONE.
  - The final beat's mismatch is included in pass.
- Latency from the last beat to the verdict is 0 cycles after the sampling edge.
- Gaps in in_valid stall the checker without limit. There is no timeout.
- When start and rst arrive together, rst wins.

## Configuration
- ADDER_CHECKER_FAIL_CAPTURE_EN defined:
  - On the first mismatching beat of a run, fail_a, fail_b, fail_sum and fail_carry register that beat's inputs.
  - They hold those values until the next start or rst.
  - Later mismatches do not overwrite them.
- ADDER_CHECKER_FAIL_CAPTURE_EN undefined: the fail_* ports remain, are tied to 0, and no capture registers are built.

## Structure
- Shared package adder_check_pkg contains:
  - the state encoding constants for IDLE, CHECK and DONE;
  - a saturating-increment function.
- Sub-module adder_golden: a combinational reference model that computes the WIDTH+1 bit value a+b. It is reusable by other datapath checkers.

## Test plan
- Reset: assert rst for 2 cycles → all outputs 0, in_ready=0, state IDLE.
- All-correct run (WIDTH=1, NUM_VECTORS=4):
  - Stimulus: start, then 4 back-to-back beats (a,b → sum,carry) = (0,0→0,0), (0,1→1,0), (1,0→1,0), (1,1→0,1).
  - Required: done pulses once, directly after the 4th beat; pass=1; vec_count=4; err_count=0.
- Single fault: same run, but beat 2 has sum=0 → err_count=1, pass=0. With ADDER_CHECKER_FAIL_CAPTURE_EN: fail_a=0, fail_b=1, fail_sum=0, fail_carry=0.
- Valid gaps: 4 beats separated by 0–3 idle cycles, plus in_valid=1 pulses in IDLE → vec_count counts only the 4 CHECK beats, and done occurs once.
- Reset mid-run: rst after 2 beats → all outputs 0. A following start and 4 correct beats give pass=1 and vec_count=4.
- Restart and saturation:
  - start pulse during CHECK → ignored, counts continue.
  - CNT_W=2, NUM_VECTORS=3, 3 faulty beats → err_count=3, which is all-ones and is held.
  - start from DONE → new run with counts cleared.

Source files
------------

// File: rtl/adder_checker_pkg.sv
// Shared definitions for the adder response checker: FSM state encoding
// and a saturating increment used by the mismatch counter.
package adder_check_pkg;

    // Run-control states of the checker.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Widest counter the saturating increment supports.
    localparam int MAX_CNT_W = 32;

    // Increment v, holding at all-ones of a w-bit counter (w <= MAX_CNT_W).
    function automatic logic [MAX_CNT_W-1:0] sat_inc(input logic [MAX_CNT_W-1:0] v,
                                                      input int unsigned     w);
        logic [MAX_CNT_W-1:0] max_v;
        max_v = (w >= MAX_CNT_W) ? '1 : ((32'd1 << w) - 32'd1);
        return (v == max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/adder_checker_if.sv
// Observed-vector handshake between the adder stimulus side (master) and
// the response checker (slave).
interface adder_checker_if #(
    parameter int WIDTH = 1
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_sum;
    logic             in_carry;

    modport master (
        output in_valid, in_a, in_b, in_sum, in_carry,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sum, in_carry,
        output in_ready
    );
endinterface

// File: rtl/adder_checker_golden.sv
// Combinational reference adder: full WIDTH+1 bit value of a+b. Kept
// standalone so other datapath checkers can reuse it.
module adder_golden #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   sum
);
    // Zero-extend both operands so the carry lands in the top bit.
    assign sum = {1'b0, a} + {1'b0, b};
endmodule

// File: rtl/adder_checker.sv
// Self-checking response monitor for the adder datapath. Counts observed
// vectors and mismatches against a golden a+b and raises a verdict after
// NUM_VECTORS beats. Optional first-failure capture is enabled by defining
// ADDER_CHECKER_FAIL_CAPTURE_EN; otherwise fail_* are tied to 0.
module adder_checker
    import adder_check_pkg::*;
#(
    parameter int WIDTH       = 1,
    parameter int NUM_VECTORS = 4,
    parameter int CNT_W       = 16   // must not exceed MAX_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    adder_checker_if.slave   vec,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic [WIDTH-1:0] fail_sum,
    output logic             fail_carry
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH:0]   golden;
    logic             beat;
    logic             last_beat;
    logic             mismatch;
    logic             run_start;
    logic [CNT_W-1:0] err_inc;

    adder_golden #(.WIDTH(WIDTH)) u_golden (
        .a   (vec.in_a),
        .b   (vec.in_b),
        .sum (golden)
    );

    // A beat is only possible in CHECK, where in_ready is high.
    assign beat      = vec.in_valid && (state == CHECK);
    assign mismatch  = ({vec.in_carry, vec.in_sum} != golden);
    assign last_beat = beat && (vec_count == CNT_W'(NUM_VECTORS - 1));
    assign run_start = start && (state != CHECK);
    assign err_inc   = CNT_W'(sat_inc(MAX_CNT_W'(err_count), CNT_W));

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    // NOTE: defaulting state_nxt first keeps every path assigned, so no
    // latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: if (start)     state_nxt = CHECK;
            CHECK:      if (last_beat) state_nxt = DONE;
            default:                   state_nxt = IDLE;
        endcase
    end

    // Moore outputs: the checker is busy and ready only while checking.
    always_comb begin
        busy         = (state == CHECK);
        vec.in_ready = (state == CHECK);
    end

    // Counters, verdict and completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            done      <= 1'b0;
            pass      <= 1'b0;
            vec_count <= '0;
            err_count <= '0;
        end else begin
            done <= last_beat;
            if (run_start) begin
                pass      <= 1'b0;
                vec_count <= '0;
                err_count <= '0;
            end else if (beat) begin
                vec_count <= vec_count + CNT_W'(1);
                if (mismatch) err_count <= err_inc;
                // Verdict includes the final beat's own mismatch.
                if (last_beat) pass <= !mismatch && (err_count == '0);
            end
        end
    end

`ifdef ADDER_CHECKER_FAIL_CAPTURE_EN
    // Capture the first mismatching beat of a run; err_count is still zero
    // only on that beat, and it never wraps back to zero.
    always_ff @(posedge clk) begin
        if (rst || run_start) begin
            fail_a     <= '0;
            fail_b     <= '0;
            fail_sum   <= '0;
            fail_carry <= 1'b0;
        end else if (beat && mismatch && (err_count == '0)) begin
            fail_a     <= vec.in_a;
            fail_b     <= vec.in_b;
            fail_sum   <= vec.in_sum;
            fail_carry <= vec.in_carry;
        end
    end
`else
    assign fail_a     = '0;
    assign fail_b     = '0;
    assign fail_sum   = '0;
    assign fail_carry = 1'b0;
`endif

endmodule

// File: tb/tb_adder_checker.sv
// Directed, table-driven bench for adder_checker: a WIDTH=1/NUM_VECTORS=4
// instance for the main runs and a CNT_W=2/NUM_VECTORS=3 instance for
// error-counter saturation.
module tb_adder_checker;

    localparam int W   = 1;
    localparam int N   = 4;
    localparam int CW  = 16;
    localparam int SN  = 3;
    localparam int SCW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, s_start;

    adder_checker_if #(.WIDTH(W)) vif ();
    adder_checker_if #(.WIDTH(W)) sif ();

    logic          busy, done, pass, fail_carry;
    logic [CW-1:0] vec_count, err_count;
    logic [W-1:0]  fail_a, fail_b, fail_sum;

    logic           s_busy, s_done, s_pass, s_fail_carry;
    logic [SCW-1:0] s_vec_count, s_err_count;
    logic [W-1:0]   s_fail_a, s_fail_b, s_fail_sum;

    adder_checker #(.WIDTH(W), .NUM_VECTORS(N), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .vec(vif),
        .busy(busy), .done(done), .pass(pass),
        .vec_count(vec_count), .err_count(err_count),
        .fail_a(fail_a), .fail_b(fail_b), .fail_sum(fail_sum), .fail_carry(fail_carry)
    );

    adder_checker #(.WIDTH(W), .NUM_VECTORS(SN), .CNT_W(SCW)) dut_sat (
        .clk(clk), .rst(rst), .start(s_start), .vec(sif),
        .busy(s_busy), .done(s_done), .pass(s_pass),
        .vec_count(s_vec_count), .err_count(s_err_count),
        .fail_a(s_fail_a), .fail_b(s_fail_b), .fail_sum(s_fail_sum), .fail_carry(s_fail_carry)
    );

    typedef struct {
        logic a, b, sum, carry;
        int   gap;       // idle cycles before this beat
        int   exp_vec;   // vec_count after the beat
        int   exp_err;   // err_count after the beat
    } beat_t;

    beat_t base[N];
    beat_t tbl[N];

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    // Count completion pulses seen by the main instance.
    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Build the run table from the base vectors, optionally corrupting one
    // beat's sum and spreading beats with 0..3 idle cycles.
    task automatic fill_tbl(input int fault_idx, input bit with_gaps);
        for (int i = 0; i < N; i++) begin
            tbl[i]         = base[i];
            tbl[i].gap     = with_gaps ? i : 0;
            tbl[i].exp_vec = i + 1;
            tbl[i].exp_err = (i >= fault_idx) ? 1 : 0;
        end
        if (fault_idx < N) tbl[fault_idx].sum = ~base[fault_idx].sum;
    endtask

    task automatic do_start(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy"},  busy, 1);
        check({tag, "_ready"}, vif.in_ready, 1);
        check({tag, "_vec0"},  vec_count, 0);
        check({tag, "_err0"},  err_count, 0);
        check({tag, "_pass0"}, pass, 0);
        check({tag, "_failb0"}, fail_b, 0);
    endtask

    task automatic apply_beat(input string tag, input int i);
        for (int g = 0; g < tbl[i].gap; g++) begin
            vif.in_valid = 1'b0;
            tick();
            check($sformatf("%s_gap%0d_vec", tag, i), vec_count, i);
            check($sformatf("%s_gap%0d_busy", tag, i), busy, 1);
        end
        vif.in_valid = 1'b1;
        vif.in_a     = tbl[i].a;
        vif.in_b     = tbl[i].b;
        vif.in_sum   = tbl[i].sum;
        vif.in_carry = tbl[i].carry;
        tick();
        vif.in_valid = 1'b0;
        check($sformatf("%s_b%0d_vec", tag, i), vec_count, tbl[i].exp_vec);
        check($sformatf("%s_b%0d_err", tag, i), err_count, tbl[i].exp_err);
        check($sformatf("%s_b%0d_done", tag, i), done, (i == N - 1) ? 1 : 0);
    endtask

    task automatic run_tbl(input string tag, input logic exp_pass, input int exp_err);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < N; i++) apply_beat(tag, i);
        check({tag, "_busy_end"}, busy, 0);
        check({tag, "_pass"}, pass, exp_pass);
        tick();
        check({tag, "_done_once"}, done_cnt - d0, 1);
        check({tag, "_done_low"}, done, 0);
        check({tag, "_vec_hold"}, vec_count, N);
        check({tag, "_err_hold"}, err_count, exp_err);
        check({tag, "_pass_hold"}, pass, exp_pass);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_ready"}, vif.in_ready, 0);
        check({tag, "_done"},  done, 0);
        check({tag, "_pass"},  pass, 0);
        check({tag, "_vec"},   vec_count, 0);
        check({tag, "_err"},   err_count, 0);
        check({tag, "_fail"},  {fail_a, fail_b, fail_sum, fail_carry}, 0);
        check({tag, "_s_busy"}, s_busy, 0);
        check({tag, "_s_cnt"},  {s_vec_count, s_err_count, s_pass, s_done}, 0);
    endtask

    task automatic check_fail(input string tag, input logic [3:0] exp_abs_c);
        check({tag, "_fail_a"},     fail_a,     exp_abs_c[3]);
        check({tag, "_fail_b"},     fail_b,     exp_abs_c[2]);
        check({tag, "_fail_sum"},   fail_sum,   exp_abs_c[1]);
        check({tag, "_fail_carry"}, fail_carry, exp_abs_c[0]);
    endtask

    initial begin
        int d0;
        // Golden half-adder vectors: (a,b -> sum,carry).
        base[0] = '{a:1'b0, b:1'b0, sum:1'b0, carry:1'b0, gap:0, exp_vec:0, exp_err:0};
        base[1] = '{a:1'b0, b:1'b1, sum:1'b1, carry:1'b0, gap:0, exp_vec:0, exp_err:0};
        base[2] = '{a:1'b1, b:1'b0, sum:1'b1, carry:1'b0, gap:0, exp_vec:0, exp_err:0};
        base[3] = '{a:1'b1, b:1'b1, sum:1'b0, carry:1'b1, gap:0, exp_vec:0, exp_err:0};

        rst = 1'b1; start = 1'b0; s_start = 1'b0;
        vif.in_valid = 1'b0; vif.in_a = '0; vif.in_b = '0; vif.in_sum = '0; vif.in_carry = 1'b0;
        sif.in_valid = 1'b0; sif.in_a = '0; sif.in_b = '0; sif.in_sum = '0; sif.in_carry = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_reset("reset");

        // in_valid while IDLE is ignored.
        vif.in_valid = 1'b1;
        tick();
        tick();
        vif.in_valid = 1'b0;
        check("idle_valid_vec", vec_count, 0);
        check("idle_valid_busy", busy, 0);

        // All-correct run.
        fill_tbl(N, 1'b0);
        do_start("ok");
        run_tbl("ok", 1'b1, 0);
        check_fail("ok", 4'b0000);

        // Single fault on beat 2: (0,1) reported with sum=0.
        fill_tbl(1, 1'b0);
        do_start("fault");
        run_tbl("fault", 1'b0, 1);
`ifdef ADDER_CHECKER_FAIL_CAPTURE_EN
        check_fail("fault", 4'b0100);
`else
        check_fail("fault", 4'b0000);
`endif

        // in_valid while DONE is ignored; results hold.
        vif.in_valid = 1'b1;
        vif.in_a = 1'b1;
        tick();
        tick();
        vif.in_valid = 1'b0;
        check("done_valid_vec", vec_count, N);
        check("done_valid_err", err_count, 1);
        check("done_valid_ready", vif.in_ready, 0);

        // Correct run with 0..3 idle cycles between beats.
        fill_tbl(N, 1'b1);
        do_start("gaps");
        run_tbl("gaps", 1'b1, 0);

        // Reset in the middle of a run: no verdict, everything cleared.
        fill_tbl(N, 1'b0);
        do_start("abort");
        apply_beat("abort", 0);
        apply_beat("abort", 1);
        d0 = done_cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset("abort_rst");
        tick();
        check("abort_no_done", done_cnt - d0, 0);
        do_start("after_abort");
        run_tbl("after_abort", 1'b1, 0);

        // start together with rst: rst wins.
        start = 1'b1;
        rst   = 1'b1;
        tick();
        start = 1'b0;
        rst   = 1'b0;
        check("rst_start_busy", busy, 0);
        check("rst_start_pass", pass, 0);

        // start during CHECK is ignored and counting continues.
        do_start("restart");
        apply_beat("restart", 0);
        apply_beat("restart", 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_busy", busy, 1);
        check("restart_vec", vec_count, 2);
        apply_beat("restart", 2);
        apply_beat("restart", 3);
        check("restart_pass", pass, 1);
        tick();

        // Saturation: CNT_W=2, three faulty beats drive err_count to 3.
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        check("sat_busy", s_busy, 1);
        for (int i = 0; i < SN; i++) begin
            sif.in_valid = 1'b1;
            sif.in_a     = 1'b0;
            sif.in_b     = 1'b1;
            sif.in_sum   = 1'b0;
            sif.in_carry = 1'b0;
            tick();
            sif.in_valid = 1'b0;
            check($sformatf("sat_b%0d_err", i), s_err_count, i + 1);
            check($sformatf("sat_b%0d_vec", i), s_vec_count, i + 1);
            check($sformatf("sat_b%0d_done", i), s_done, (i == SN - 1) ? 1 : 0);
        end
        check("sat_pass", s_pass, 0);
        check("sat_busy_end", s_busy, 0);
        tick();
        check("sat_err_hold", s_err_count, 3);
        check("sat_done_low", s_done, 0);

        // start from DONE begins a fresh run with cleared counters.
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        check("sat_restart_busy", s_busy, 1);
        check("sat_restart_err", s_err_count, 0);
        check("sat_restart_vec", s_vec_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
